// File: rtl/nrs_read_scheduler.sv
// Arbitrates estimator / fine-sync readers over one stored NRS slot sequence.
// Optional fine-sync path enabled by defining FINE_SYNC_EN.
module nrs_read_scheduler #(
  parameter int WIDTH_REG = 16,
  parameter int LINES     = $clog2(WIDTH_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_frame,
  input  logic             NRS_gen_ready,
  input  logic             nrs_bit,
  input  logic             est_req,
  input  logic             fine_req,
  output logic [LINES-1:0] rd_addr,
  output logic             est_ack,
  output logic             est_valid,
  output logic             est_bit,
  output logic             est_last,
  output logic             fine_valid,
  output logic             fine_bit,
  output logic             fine_last,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, SERVE_EST, SERVE_FINE, ACK, WAIT_DROP} state_t;

  localparam logic [LINES-1:0] LAST_ADDR = LINES'(WIDTH_REG - 1);

  state_t           state, state_nxt;
  logic [LINES-1:0] cnt, cnt_nxt;
  logic             drain, drain_nxt;
  logic             clr_served;
  logic             served_est, served_fine;
  logic             est_vld_p1, est_last_p1, fine_vld_p1, fine_last_p1;
  logic             fine_req_en, est_pend, fine_pend, serving, issue_addr, overrun_hit;

`ifdef FINE_SYNC_EN
  assign fine_req_en = fine_req;
  assign fine_valid  = fine_vld_p1;
  assign fine_bit    = fine_vld_p1 & nrs_bit;
  assign fine_last   = fine_last_p1;
`else
  logic unused_fine;
  assign fine_req_en = 1'b0;
  assign fine_valid  = 1'b0;
  assign fine_bit    = 1'b0;
  assign fine_last   = 1'b0;
  assign unused_fine = ^{fine_req, fine_vld_p1, fine_last_p1};
`endif

  assign est_pend    = est_req & ~served_est;
  assign fine_pend   = fine_req_en & ~served_fine;
  assign serving     = (state == SERVE_EST) || (state == SERVE_FINE);
  // drain is the extra cycle in which the last read bit is presented
  assign issue_addr  = serving & ~drain & ~new_frame;
  assign overrun_hit = (state != WAIT_DROP) &
                       ((est_req & served_est) | (fine_req_en & served_fine));

  assign rd_addr   = serving ? cnt : '0;
  assign est_ack   = (state == ACK);
  assign busy      = (state != IDLE);
  assign est_valid = est_vld_p1;
  assign est_bit   = est_vld_p1 & nrs_bit;
  assign est_last  = est_last_p1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    drain_nxt  = drain;
    clr_served = 1'b0;
    case (state)
      IDLE: begin
        if (NRS_gen_ready && est_pend) begin
          state_nxt = SERVE_EST;
          cnt_nxt   = '0;
        end else if (NRS_gen_ready && fine_pend) begin
          state_nxt = SERVE_FINE;
          cnt_nxt   = '0;
        end
      end
      SERVE_EST, SERVE_FINE: begin
        if (!drain) begin
          if (cnt == LAST_ADDR) begin
            // fine stream follows the estimator stream with no gap
            if (state == SERVE_EST && fine_pend) begin
              state_nxt = SERVE_FINE;
              cnt_nxt   = '0;
            end else begin
              drain_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          drain_nxt = 1'b0;
          cnt_nxt   = '0;
          if (state == SERVE_EST && fine_pend)
            state_nxt = SERVE_FINE;
          else if (state == SERVE_EST || served_est)
            state_nxt = ACK;
          else
            state_nxt = IDLE;
        end
      end
      ACK: state_nxt = WAIT_DROP;
      WAIT_DROP: begin
        if (!NRS_gen_ready) begin
          state_nxt  = IDLE;
          clr_served = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (new_frame) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      drain_nxt  = 1'b0;
      clr_served = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      drain        <= 1'b0;
      served_est   <= 1'b0;
      served_fine  <= 1'b0;
      overrun      <= 1'b0;
      est_vld_p1   <= 1'b0;
      est_last_p1  <= 1'b0;
      fine_vld_p1  <= 1'b0;
      fine_last_p1 <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      drain        <= drain_nxt;
      served_est   <= ~clr_served & (served_est | est_last_p1);
      served_fine  <= ~clr_served & (served_fine | fine_last_p1);
      overrun      <= overrun | overrun_hit;
      // p1: read data for the address issued last cycle is on nrs_bit
      est_vld_p1   <= issue_addr & (state == SERVE_EST);
      est_last_p1  <= issue_addr & (state == SERVE_EST) & (cnt == LAST_ADDR);
      fine_vld_p1  <= issue_addr & (state == SERVE_FINE);
      fine_last_p1 <= issue_addr & (state == SERVE_FINE) & (cnt == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_nrs_read_scheduler.sv
// Randomized bench for nrs_read_scheduler against a slot-level reference model.
module tb_nrs_read_scheduler;
  localparam int W  = 16;
  localparam int LW = $clog2(W);
`ifdef FINE_SYNC_EN
  localparam bit FINE_ON = 1'b1;
`else
  localparam bit FINE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, new_frame, NRS_gen_ready, nrs_bit, est_req, fine_req;
  logic [LW-1:0] rd_addr;
  logic          est_ack, est_valid, est_bit, est_last;
  logic          fine_valid, fine_bit, fine_last, busy, overrun;
  logic [W-1:0]  mem;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  // stored slot sequence, one-cycle read latency
  always @(posedge clk) nrs_bit <= mem[rd_addr];

  nrs_read_scheduler #(.WIDTH_REG(W)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .NRS_gen_ready(NRS_gen_ready),
    .nrs_bit(nrs_bit), .est_req(est_req), .fine_req(fine_req), .rd_addr(rd_addr),
    .est_ack(est_ack), .est_valid(est_valid), .est_bit(est_bit), .est_last(est_last),
    .fine_valid(fine_valid), .fine_bit(fine_bit), .fine_last(fine_last),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_new_frame();
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    @(negedge clk);
  endtask

  // One slot: requests e/f, ready rises after dly cycles; the model predicts
  // which streams appear, their cycle positions and the ack position.
  task automatic run_slot(input bit e, input bit f, input int dly);
    int est_first = -1, est_lastk = -1, fine_first = -1, fine_lastk = -1, ack_k = -1;
    int n_est = 0, n_fine = 0, n_estl = 0, n_finel = 0, n_ack = 0, n_both = 0, early = 0;
    logic [W-1:0] est_got = '0, fine_got = '0;
    bit exp_e, exp_f;
    int x_fine_first, x_fine_last, x_ack;
    mem = W'($urandom);
    @(negedge clk);
    est_req = e; fine_req = f; NRS_gen_ready = 1'b0;
    repeat (dly) begin
      @(negedge clk);
      if (busy || est_valid || fine_valid) early++;
    end
    check("idle_while_not_ready", early, 0);
    NRS_gen_ready = 1'b1;
    for (int k = 0; k < 2 * W + 12; k++) begin
      @(negedge clk);
      if (est_valid && fine_valid) n_both++;
      if (est_valid) begin
        if (est_first < 0) est_first = k;
        if (n_est < W) est_got[n_est] = est_bit;
        n_est++;
      end
      if (fine_valid) begin
        if (fine_first < 0) fine_first = k;
        if (n_fine < W) fine_got[n_fine] = fine_bit;
        n_fine++;
      end
      if (est_last) begin n_estl++; est_lastk = k; est_req = 1'b0; end
      if (fine_last) begin n_finel++; fine_lastk = k; fine_req = 1'b0; end
      if (est_ack) begin n_ack++; ack_k = k; end
    end
    exp_e = e;
    exp_f = f & FINE_ON;
    x_fine_first = exp_f ? (exp_e ? W + 1 : 1) : -1;
    x_fine_last  = exp_f ? x_fine_first + W - 1 : -1;
    x_ack        = exp_e ? (exp_f ? x_fine_last + 1 : W + 1) : -1;
    check("est_bits", est_got, exp_e ? mem : '0);
    check("est_count", n_est, exp_e ? W : 0);
    check("est_first", est_first, exp_e ? 1 : -1);
    check("est_last_pos", est_lastk, exp_e ? W : -1);
    check("est_last_count", n_estl, exp_e ? 1 : 0);
    check("fine_bits", fine_got, exp_f ? mem : '0);
    check("fine_count", n_fine, exp_f ? W : 0);
    check("fine_first", fine_first, x_fine_first);
    check("fine_last_pos", fine_lastk, x_fine_last);
    check("fine_last_count", n_finel, exp_f ? 1 : 0);
    check("ack_count", n_ack, exp_e ? 1 : 0);
    check("ack_pos", ack_k, x_ack);
    check("both_valid", n_both, 0);
    check("busy_hold", busy, exp_e);
    NRS_gen_ready = 1'b0; est_req = 1'b0; fine_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_drop", busy, 0);
    check("no_overrun", overrun, 0);
    pulse_new_frame();
  endtask

  // Start an estimator stream, return once rd_addr reaches addr (bounded).
  task automatic start_est_until(input logic [LW-1:0] addr, output bit found);
    found = 1'b0;
    mem = W'($urandom);
    est_req = 1'b1; NRS_gen_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy && rd_addr == addr) begin found = 1'b1; break; end
    end
  endtask

  task automatic quiet_window(input string tag);
    int n_l = 0, n_a = 0;
    repeat (20) begin
      @(negedge clk);
      if (est_last || fine_last) n_l++;
      if (est_ack) n_a++;
    end
    check({tag, "_no_last"}, n_l, 0);
    check({tag, "_no_ack"}, n_a, 0);
  endtask

  initial begin
    bit found;
    int n_est;
    rst = 1'b1; new_frame = 1'b0; NRS_gen_ready = 1'b0; est_req = 1'b0; fine_req = 1'b0;
    mem = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", est_ack, 0);
    check("rst_est_valid", est_valid, 0);
    check("rst_est_last", est_last, 0);
    check("rst_fine_valid", fine_valid, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    run_slot(1'b1, 1'b0, 0);
    run_slot(1'b1, 1'b1, 0);
    run_slot(1'b1, 1'b0, 10);
    run_slot(1'b0, 1'b1, 2);
    for (int s = 0; s < 10; s++)
      run_slot(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5));

    // frame boundary in the middle of an estimator stream
    start_est_until(LW'(7), found);
    check("nf_reach_addr7", found, 1);
    new_frame = 1'b1; est_req = 1'b0;
    @(negedge clk);
    new_frame = 1'b0;
    check("nf_busy", busy, 0);
    check("nf_valid", est_valid, 0);
    quiet_window("nf");
    NRS_gen_ready = 1'b0;
    run_slot(1'b1, 1'b0, 1);

    // synchronous reset in the middle of a stream
    start_est_until(LW'(10), found);
    check("rst_reach_addr10", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; est_req = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", est_valid, 0);
    check("rstmid_rd_addr", rd_addr, 0);
    quiet_window("rstmid");
    NRS_gen_ready = 1'b0;
    @(negedge clk);

    // estimator keeps requesting after its stream: overrun, no second stream
    mem = W'($urandom);
    est_req = 1'b1; NRS_gen_ready = 1'b1; n_est = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (est_valid) n_est++;
    end
    check("ovr_set", overrun, 1);
    check("ovr_one_stream", n_est, W);
    NRS_gen_ready = 1'b0; est_req = 1'b0;
    repeat (3) @(negedge clk);
    pulse_new_frame();
    check("ovr_sticky", overrun, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ovr_rst_clear", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nrs_read_scheduler.md
NRS_READ_SCHEDULER -- requirements
Module: nrs_read_scheduler

Interface
REQ-001 Parameters (name, default, meaning): WIDTH_REG, 16, NRS bits per slot; LINES, $clog2(WIDTH_REG), read-address width.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 new_frame  input  1  frame-boundary pulse; aborts service.
REQ-005 NRS_gen_ready  input  1  generator has a complete slot sequence stored.
REQ-006 nrs_bit  input  1  NRS register read data; valid one cycle after rd_addr.
REQ-007 est_req  input  1  estimator request, level; held until est_last.
REQ-008 fine_req  input  1  fine-sync request, level; held until fine_last.
REQ-009 rd_addr  output  LINES  NRS register read address.
REQ-010 est_ack  output  1  one-cycle pulse releasing the generator to the next slot.
REQ-011 est_valid, est_bit, est_last  output  1 each  estimator data stream.
REQ-012 fine_valid, fine_bit, fine_last  output  1 each  fine-sync data stream.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  sticky: a requester re-requested in a slot where it was already served.

Function
REQ-015 FSM states: IDLE, SERVE_EST, SERVE_FINE, ACK, WAIT_DROP.
REQ-016 IDLE: if NRS_gen_ready=1 and an unserved request is pending, grant on the next edge; est_req has priority when both are pending.
REQ-017 SERVE_x: rd_addr counts 0..WIDTH_REG-1, one step per cycle; x_valid=1 and x_bit=nrs_bit exactly one cycle after each address, so the stream lasts WIDTH_REG cycles; x_last coincides with the bit for address WIDTH_REG-1.
REQ-018 After x_last, set served_x for this slot. Go to SERVE_FINE if fine_req is pending and unserved. Otherwise go to ACK if served_est=1. Otherwise go to IDLE.
REQ-019 ACK: est_ack=1 for exactly one cycle, then go to WAIT_DROP.
REQ-020 WAIT_DROP: hold until NRS_gen_ready=0, then clear served flags and go to IDLE; no grants occur in WAIT_DROP.
REQ-021 rd_addr wraps from WIDTH_REG-1 to 0 only on a new grant; it holds 0 outside SERVE states.
REQ-022 Request not seen while NRS_gen_ready=0: stays pending with no response.
REQ-023 new_frame=1 in any state: on the next edge go to IDLE, clear served flags and counter, deassert all valid/last outputs, and do not issue est_ack; new_frame takes precedence over every other transition in the same cycle.
REQ-024 A request from an already-served requester in the same slot (outside WAIT_DROP) is ignored and sets overrun; overrun clears only on rst.
REQ-025 Only one requester is served at a time; est_valid and fine_valid are never high together.

Reset
REQ-026 rst=1 at an edge: state=IDLE, rd_addr=0, counter=0, served flags=0, overrun=0, est_ack=0, busy=0, all valid/bit/last outputs=0.
REQ-027 rst mid-service truncates the stream immediately; no x_last and no est_ack is produced.

Configuration
REQ-028 Macro FINE_SYNC_EN: when defined, the fine-sync path operates as specified above.
REQ-029 When FINE_SYNC_EN is undefined, fine_req is ignored, fine_valid/fine_bit/fine_last are constant 0, SERVE_FINE is unreachable, and est_ack follows est_last directly via ACK.

Verification
REQ-030 Case: reset, NRS_gen_ready=1, est_req=1 -> grant next edge; rd_addr 0..15; est_valid for 16 cycles; est_last on cycle 16; est_ack pulses once; then WAIT_DROP.
REQ-031 Case (FINE_SYNC_EN): est_req=fine_req=1 same cycle -> 16 estimator bits, then 16 fine bits back-to-back; est_ack after fine_last; never both valids high.
REQ-032 Case: est_req=1 while NRS_gen_ready=0 for 10 cycles -> no activity, busy=0; ready rises -> service starts on the next edge.
REQ-033 Case: new_frame at rd_addr=7 of SERVE_EST -> IDLE next cycle, no est_last, no est_ack, served flags=0.
REQ-034 Case: est_req re-asserted after est_last before ACK -> overrun=1, no second stream, overrun stays 1 until rst.
REQ-035 Case (FINE_SYNC_EN undefined): fine_req=1 only -> no service, fine outputs 0, est_ack never pulses.
